// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : multi-cycle restoring integer divider for the execute stage.
//
// Accepts a divide request, retires one quotient bit per cycle and returns
// {remainder, quotient} for the hi/lo write path (hi = remainder,
// lo = quotient). Signed mode divides magnitudes and sign-corrects the
// result: the quotient truncates toward zero and the remainder takes the
// dividend's sign. Divide by zero completes in one cycle with a zero result.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   start_in       : divide request, held until ready_out is seen
//   signed_in      : 1 = signed divide, 0 = unsigned; sampled with start
//   dividend_in    : dividend, sampled when a start is accepted
//   divisor_in     : divisor, sampled when a start is accepted
//   annul_in       : flush; blocks acceptance and aborts a running divide
//   result_out     : {remainder, quotient}, registered, holds until reloaded
//   ready_out      : one-cycle result-valid pulse (registered)
//   stall_req_out  : combinational pipeline stall request
// ---------------------------------------------------------------------------
module div_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_in,
    input  logic                      signed_in,
    input  logic [DATA_WIDTH-1:0]     dividend_in,
    input  logic [DATA_WIDTH-1:0]     divisor_in,
    input  logic                      annul_in,
    output logic [2*DATA_WIDTH-1:0]   result_out,
    output logic                      ready_out,
    output logic                      stall_req_out
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;

    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [W:0]            rem_reg;      // partial remainder
    logic [W-1:0]          dvd_reg;      // dividend shifts out, quotient shifts in
    logic [W-1:0]          dsr_reg;      // divisor magnitude
    logic                  sign_a_reg;
    logic                  sign_b_reg;
    logic                  signed_reg;
    logic [2*W-1:0]        result_reg;
    logic                  ready_reg;

    // FSM-issued datapath controls
    logic                  start_div;
    logic                  zero_div;
    logic                  do_step;
    logic                  finish;

    // ---------------------------------------------------------------
    // Operand magnitudes at acceptance
    // ---------------------------------------------------------------
    logic                  a_neg, b_neg;
    logic [W-1:0]          a_mag, b_mag;

    assign a_neg = signed_in & dividend_in[W-1];
    assign b_neg = signed_in & divisor_in[W-1];
    assign a_mag = a_neg ? -dividend_in : dividend_in;
    assign b_mag = b_neg ? -divisor_in  : divisor_in;

    // ---------------------------------------------------------------
    // One restoring step. The remainder is always below the divisor, so
    // rem_reg[W] stays 0; carrying it keeps the trial one uniform width
    // with a spare sign bit on top.
    // ---------------------------------------------------------------
    logic [W+1:0]          wide;
    logic [W+1:0]          trial;
    logic                  trial_ok;
    logic [W:0]            rem_step;
    logic [W-1:0]          quo_step;

    assign wide     = {rem_reg, dvd_reg[W-1]};
    assign trial    = wide - {2'b00, dsr_reg};
    assign trial_ok = ~trial[W+1];
    assign rem_step = trial_ok ? trial[W:0] : wide[W:0];
    assign quo_step = {dvd_reg[W-2:0], trial_ok};

    // Sign correction applied to the final step's values
    logic                  neg_q, neg_r;
    logic [W-1:0]          quo_fix, rem_fix;

    assign neg_q   = signed_reg & (sign_a_reg ^ sign_b_reg);
    assign neg_r   = signed_reg & sign_a_reg;
    assign quo_fix = neg_q ? -quo_step : quo_step;
    assign rem_fix = neg_r ? -rem_step[W-1:0] : rem_step[W-1:0];

    logic                  last_step;
    assign last_step = (cnt_reg == CNT_WIDTH'(W - 1));

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        stall_req_out = 1'b0;
        start_div     = 1'b0;
        zero_div      = 1'b0;
        do_step       = 1'b0;
        finish        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_in && !annul_in) begin
                    stall_req_out = 1'b1;
                    if (divisor_in == '0) begin
                        zero_div   = 1'b1;
                        state_next = DONE;
                    end else begin
                        start_div  = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_req_out = 1'b1;
                if (annul_in) begin
                    state_next = IDLE;
                end else begin
                    do_step = 1'b1;
                    if (last_step) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvd_reg    <= '0;
            dsr_reg    <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            signed_reg <= 1'b0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            // ready is registered from the next-state decode so the pulse
            // lines up with DONE without decoding the state bits downstream
            ready_reg <= (state_next == DONE);
            if (start_div) begin
                cnt_reg    <= '0;
                rem_reg    <= '0;
                dvd_reg    <= a_mag;
                dsr_reg    <= b_mag;
                sign_a_reg <= dividend_in[W-1];
                sign_b_reg <= divisor_in[W-1];
                signed_reg <= signed_in;
            end
            if (zero_div) begin
                result_reg <= '0;
            end
            if (do_step) begin
                rem_reg <= rem_step;
                dvd_reg <= quo_step;
                cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end
            if (finish) begin
                result_reg <= {rem_fix, quo_fix};
            end
        end
    end

    assign result_out = result_reg;
    assign ready_out  = ready_reg;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle integer divide sequencer for the execute stage. It accepts a divide request from `ex` and runs a 1-bit-per-cycle restoring division, signed or unsigned. While busy it holds a pipeline stall request. It returns `{remainder, quotient}` for the hi/lo register write path: hi = remainder, lo = quotient. It is instantiated beside `ex`, ahead of `ex_mem`.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand width W; must be ≥ 2.
- `CNT_WIDTH`, default 6: step counter width; must satisfy 2^CNT_WIDTH > W.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_in` input 1: divide request from `ex`; held high until `ready_out` is seen.
- `signed_in` input 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_in`.
- `dividend_in` input W: dividend; sampled when a start is accepted.
- `divisor_in` input W: divisor; sampled when a start is accepted.
- `annul_in` input 1: cancels a pending or running divide (flush from branch or exception).
- `result_out` output 2W: `{remainder[W-1:0], quotient[W-1:0]}`; registered.
- `ready_out` output 1: result valid; high for exactly one cycle.
- `stall_req_out` output 1: stall request to the pipeline controller; combinational.

## Operation
- States, 2-bit encoding: IDLE=0, BUSY=1, DONE=2. Value 3 is illegal and returns to IDLE.
- IDLE:
  - Start is accepted when `start_in && !annul_in`.
  - If the divisor is 0: go to DONE and load `result_out` = 0.
  - Otherwise: latch the magnitudes of the operands (two's-complement absolute value when `signed_in`), latch both sign bits and `signed_in`, clear the partial remainder (W+1 bits) and the counter, then go to BUSY.
- BUSY, one step per cycle:
  - Form trial = {rem[W-1:0], next dividend MSB} − {1'b0, divisor}.
  - If trial ≥ 0: rem = trial and shift 1 into the quotient.
  - Otherwise: shift the dividend bit into rem and shift 0 into the quotient.
  - The counter increments each step.
  - On the step where counter = W−1, go to DONE and load `result_out` with the sign-corrected result.
- Sign correction, signed mode only:
  - The quotient is negated when the dividend and divisor signs differ.
  - The remainder is negated when the dividend is negative, so it takes the dividend's sign.
  - Arithmetic is modulo 2^W. The case 0x80000000 / −1 yields quotient 0x80000000 and remainder 0, with no trap.
- DONE:
  - `ready_out` = 1.
  - Go to IDLE unconditionally on the next edge.
  - `start_in` is not re-sampled in DONE.
- `annul_in`:
  - In BUSY: go to IDLE on the next edge; `ready_out` is never asserted and `result_out` keeps its previous value.
  - In IDLE: blocks acceptance.
  - In DONE: no effect.
- `stall_req_out` = (IDLE && `start_in` && !`annul_in`) || BUSY. It is low in DONE so the instruction advances with its result.
- `result_out` holds its last value until the next load or reset.

## Timing
- Reset, asynchronous: state = IDLE, `result_out` = 0, `ready_out` = 0. The counter, internal remainder, quotient, operands and sign registers are cleared. `stall_req_out` = 0 unless `start_in` is high with `annul_in` low (it is combinational, as defined in Operation).
- Normal divide, start accepted in cycle 0:
  - BUSY during cycles 1..W.
  - DONE in cycle W+1: `ready_out` = 1 and `result_out` valid.
  - `stall_req_out` is high in cycles 0..W.
- Divide by zero: DONE in cycle 1 with `result_out` = 0. `stall_req_out` is high in cycle 0 only.
- Back-to-back divides: the earliest next acceptance is the cycle after DONE, i.e. IDLE in cycle W+2.
- Reset asserted mid-BUSY: all outputs go to their reset values immediately. No `ready_out` is produced for the aborted divide.
- `ready_out` is a registered state decode; it never glitches.

## Test plan
- Unsigned 100 / 7 (`signed_in` = 0), start in cycle 0:
  - `stall_req_out` high in cycles 0..32.
  - `ready_out` is a single pulse in cycle 33.
  - `result_out` = {0x00000002, 0x0000000E}.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): `result_out` = {0xFFFFFFFF, 0xFFFFFFFD}. Also check 7 / −2, giving {0x00000001, 0xFFFFFFFD}.
- Divisor 0, dividend 0x12345678:
  - `ready_out` in cycle 1 and `result_out` = 0.
  - `stall_req_out` is low again by cycle 1.
- Annul: start 0xFFFFFFFF / 3, then pulse `annul_in` in cycle 10.
  - State is IDLE in cycle 11 and no `ready_out` is produced.
  - A new start in cycle 12 for 9 / 3 gives `ready_out` in cycle 45 with {0, 3}.
- Signed 0x80000000 / 0xFFFFFFFF: `result_out` = {0x00000000, 0x80000000}. Also unsigned 0xFFFFFFFF / 1: {0, 0xFFFFFFFF}.
- Reset: assert `rst` in cycle 15 of a divide.
  - `result_out`, `ready_out` and `stall_req_out` are 0 in the same cycle.
  - After release, a fresh 100 / 7 completes with the correct result.
